// File: rtl/gemm_isa_pkg.sv
// Shared ISA definitions for the GEMM instruction sequencer: opcodes,
// instruction field layout, controller state codes and sequencer FSM states.
package gemm_isa_pkg;

  localparam int OPCODE_W  = 4;
  localparam int BUF_ID_W  = 2;
  localparam int MEM_LOC_W = 10;
  localparam int INST_W    = OPCODE_W + BUF_ID_W + MEM_LOC_W;

  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_LD    = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_ST    = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_GEMM  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_DRAIN = 4'b0101;

  localparam logic [3:0] CTRL_IDLE   = 4'd0;
  localparam logic [3:0] CTRL_STEADY = 4'd1;
  localparam logic [3:0] CTRL_DRAIN  = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_GEMM,
    S_DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [BUF_ID_W-1:0]  buf_id;
    logic [MEM_LOC_W-1:0] mem_loc;
  } inst_t;

endpackage

// File: rtl/gemm_inst_decode.sv
// Combinational instruction field extraction and legality check.
// Loads may only target buffers 00 (left) and 01 (top).
module gemm_inst_decode
  import gemm_isa_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output inst_t             fields,
  output logic              illegal
);

  always_comb begin
    fields  = inst_t'(inst);
    illegal = 1'b0;
    case (fields.opcode)
      OP_HALT, OP_ST, OP_GEMM, OP_DRAIN: illegal = 1'b0;
      OP_LD:                             illegal = fields.buf_id[1];
      default:                           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/gemm_inst_sequencer.sv
// GEMM instruction sequencer: fetches, decodes and executes LD/ST/GEMM/DRAINSYS/HALT.
// Optional GEMM_SEQ_PERF_CNT_EN adds saturating performance counters.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; done pulses here after program end
// S_FETCH  | instruction memory read issued at pc
// S_DECODE | instruction returned, registered and dispatched
// S_LOAD   | ld_req held until ld_ack
// S_STORE  | st_req held until st_ack
// S_GEMM   | controller in STEADY for NUM_ROW+NUM_COL-1 cycles
// S_DRAIN  | controller in DRAIN for NUM_ROW cycles
module gemm_inst_sequencer
  import gemm_isa_pkg::*;
#(
  parameter int INST_WIDTH            = 16,
  parameter int LOG2_INST_MEMORY_SIZE = 10,
  parameter int NUM_ROW               = 8,
  parameter int NUM_COL               = 8,
  parameter int LOG2_SRAM_BANK_DEPTH  = 10,
  parameter int CTRL_WIDTH            = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             inst_rd_en,
  output logic [LOG2_INST_MEMORY_SIZE-1:0] inst_rd_addr,
  input  logic [INST_WIDTH-1:0]            inst_rd_data,
  output logic                             ld_req,
  output logic [1:0]                       ld_buf_id,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  ld_addr,
  input  logic                             ld_ack,
  output logic                             st_req,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  st_addr,
  input  logic                             st_ack,
  output logic [CTRL_WIDTH-1:0]            ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  top_rd_start,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  top_rd_end,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  left_rd_start,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  left_rd_end,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  down_rd_start,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]  down_rd_end
`ifdef GEMM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_inst_cnt,
  output logic [31:0]                      perf_busy_cyc
`endif
);

  localparam int PW        = LOG2_INST_MEMORY_SIZE;
  localparam int AW        = LOG2_SRAM_BANK_DEPTH;
  localparam int GEMM_CYC  = NUM_ROW + NUM_COL - 1;
  localparam int DRAIN_CYC = NUM_ROW;
  localparam int CNT_W     = $clog2(NUM_ROW + NUM_COL);

  localparam logic [AW-1:0] LD_SPAN = AW'(NUM_ROW + NUM_COL - 2);
  localparam logic [AW-1:0] ST_SPAN = AW'(NUM_ROW - 1);

  seq_state_e        state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [1:0]        buf_q, buf_d;
  logic [AW-1:0]     loc_q, loc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [AW-1:0]     left_s_q, left_s_d, left_e_q, left_e_d;
  logic [AW-1:0]     top_s_q, top_s_d, top_e_q, top_e_d;
  logic [AW-1:0]     down_s_q, down_s_d, down_e_q, down_e_d;

  inst_t             dec_fields;
  logic              dec_illegal;
  logic              start_accept;

  gemm_inst_decode u_decode (
    .inst    (inst_rd_data[INST_W-1:0]),
    .fields  (dec_fields),
    .illegal (dec_illegal)
  );

  assign start_accept = (state_q == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      buf_q    <= '0;
      loc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      left_s_q <= '0;
      left_e_q <= '0;
      top_s_q  <= '0;
      top_e_q  <= '0;
      down_s_q <= '0;
      down_e_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      loc_q    <= loc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      left_s_q <= left_s_d;
      left_e_q <= left_e_d;
      top_s_q  <= top_s_d;
      top_e_q  <= top_e_d;
      down_s_q <= down_s_d;
      down_e_q <= down_e_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    loc_d    = loc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    left_s_d = left_s_q;
    left_e_d = left_e_q;
    top_s_d  = top_s_q;
    top_e_d  = top_e_q;
    down_s_d = down_s_q;
    down_e_d = down_e_q;
    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          pc_d    = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        buf_d = dec_fields.buf_id;
        loc_d = AW'(dec_fields.mem_loc);
        if (dec_illegal || dec_fields.opcode == OP_HALT) begin
          err_d   = err_q | dec_illegal;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          case (dec_fields.opcode)
            OP_LD:    state_d = S_LOAD;
            OP_ST:    state_d = S_STORE;
            OP_GEMM: begin
              cnt_d   = CNT_W'(GEMM_CYC - 1);
              state_d = S_GEMM;
            end
            OP_DRAIN: begin
              cnt_d   = CNT_W'(DRAIN_CYC - 1);
              state_d = S_DRAIN;
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (ld_ack) begin
          // buf_id[1] is never set here; illegal buffers end the program in DECODE
          if (buf_q[0]) begin
            top_s_d = loc_q;
            top_e_d = loc_q + LD_SPAN;
          end else begin
            left_s_d = loc_q;
            left_e_d = loc_q + LD_SPAN;
          end
          pc_d    = pc_q + PW'(1);
          state_d = S_FETCH;
        end
      end
      S_STORE: begin
        if (st_ack) begin
          down_s_d = loc_q;
          down_e_d = loc_q + ST_SPAN;
          pc_d     = pc_q + PW'(1);
          state_d  = S_FETCH;
        end
      end
      S_GEMM, S_DRAIN: begin
        if (cnt_q == '0) begin
          pc_d    = pc_q + PW'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_rd_en   = (state_q == S_FETCH);
    inst_rd_addr = inst_rd_en ? pc_q : '0;
    ld_req       = (state_q == S_LOAD);
    ld_buf_id    = ld_req ? buf_q : '0;
    ld_addr      = ld_req ? loc_q : '0;
    st_req       = (state_q == S_STORE);
    st_addr      = st_req ? loc_q : '0;
    case (state_q)
      S_GEMM:  ctrl_state = CTRL_WIDTH'(CTRL_STEADY);
      S_DRAIN: ctrl_state = CTRL_WIDTH'(CTRL_DRAIN);
      default: ctrl_state = CTRL_WIDTH'(CTRL_IDLE);
    endcase
    busy          = busy_q;
    done          = done_q;
    err           = err_q;
    left_rd_start = left_s_q;
    left_rd_end   = left_e_q;
    top_rd_start  = top_s_q;
    top_rd_end    = top_e_q;
    down_rd_start = down_s_q;
    down_rd_end   = down_e_q;
  end

`ifdef GEMM_SEQ_PERF_CNT_EN
  logic [31:0] perf_inst_q, perf_inst_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_inst_q <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_inst_q <= perf_inst_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  always_comb begin
    perf_inst_d = perf_inst_q;
    perf_busy_d = perf_busy_q;
    if (start_accept) begin
      perf_inst_d = '0;
      perf_busy_d = '0;
    end else begin
      if (state_q == S_DECODE && perf_inst_q != '1) perf_inst_d = perf_inst_q + 32'd1;
      if (busy_q && perf_busy_q != '1)              perf_busy_d = perf_busy_q + 32'd1;
    end
  end

  assign perf_inst_cnt = perf_inst_q;
  assign perf_busy_cyc = perf_busy_q;
`endif

endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// Scoreboard bench for gemm_inst_sequencer: a program-level reference model
// queues expected events, a negedge monitor pops and compares observed ones.
module tb_gemm_inst_sequencer;

  localparam int NR = 8;
  localparam int NC = 8;
  localparam int GEMM_LEN  = NR + NC - 1;
  localparam int DRAIN_LEN = NR;

  localparam int K_LD = 1, K_ST = 2, K_STEADY = 3, K_DRAIN = 4, K_DONE = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic        inst_rd_en;
  logic [9:0]  inst_rd_addr;
  logic [15:0] inst_rd_data = '0;
  logic        ld_req;
  logic [1:0]  ld_buf_id;
  logic [9:0]  ld_addr;
  logic        ld_ack = 1'b0;
  logic        st_req;
  logic [9:0]  st_addr;
  logic        st_ack = 1'b0;
  logic [3:0]  ctrl_state;
  logic [9:0]  top_rd_start, top_rd_end, left_rd_start, left_rd_end, down_rd_start, down_rd_end;
`ifdef GEMM_SEQ_PERF_CNT_EN
  logic [31:0] perf_inst_cnt, perf_busy_cyc;
`endif

  always #5 clk = ~clk;

  gemm_inst_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .inst_rd_en(inst_rd_en), .inst_rd_addr(inst_rd_addr), .inst_rd_data(inst_rd_data),
    .ld_req(ld_req), .ld_buf_id(ld_buf_id), .ld_addr(ld_addr), .ld_ack(ld_ack),
    .st_req(st_req), .st_addr(st_addr), .st_ack(st_ack), .ctrl_state(ctrl_state),
    .top_rd_start(top_rd_start), .top_rd_end(top_rd_end),
    .left_rd_start(left_rd_start), .left_rd_end(left_rd_end),
    .down_rd_start(down_rd_start), .down_rd_end(down_rd_end)
`ifdef GEMM_SEQ_PERF_CNT_EN
    , .perf_inst_cnt(perf_inst_cnt), .perf_busy_cyc(perf_busy_cyc)
`endif
  );

  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [63:0] b;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  logic [15:0] imem [1024];
  int  ack_dly = 3;
  bit  st_auto = 1'b1;
  bit  spur_st = 1'b0;

  logic [9:0] m_ls = '0, m_le = '0, m_ts = '0, m_te = '0, m_ds = '0, m_de = '0;
  bit         m_err = 1'b0;

  always @(posedge clk) if (inst_rd_en) inst_rd_data <= imem[inst_rd_addr];

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int bf, input int loc);
    logic [3:0] o;
    logic [1:0] b;
    logic [9:0] l;
    o = 4'(op);
    b = 2'(bf);
    l = 10'(loc);
    return {o, b, l};
  endfunction

  function automatic logic [63:0] regs_pack(input logic [9:0] ts, te, ls, le, ds, de);
    return {4'b0, ts, te, ls, le, ds, de};
  endfunction

  task automatic push(input int k, input logic [63:0] a, input logic [63:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  // Programs have no branches, so execution is simply the listing in order.
  task automatic model_run(input logic [15:0] prog[$]);
    m_err = 1'b0;
    foreach (prog[k]) begin
      logic [3:0] op;
      logic [1:0] bf;
      logic [9:0] loc;
      op = prog[k][15:12];
      bf = prog[k][11:10];
      loc = prog[k][9:0];
      if (op == 4'h2 && bf < 2) begin
        push(K_LD, 64'(bf), 64'(loc));
        if (bf == 0) begin m_ls = loc; m_le = loc + 10'(NR + NC - 2); end
        else         begin m_ts = loc; m_te = loc + 10'(NR + NC - 2); end
      end else if (op == 4'h3) begin
        push(K_ST, 64'(loc), 64'd0);
        m_ds = loc; m_de = loc + 10'(NR - 1);
      end else if (op == 4'h4) begin
        push(K_STEADY, 64'(GEMM_LEN), 64'd0);
      end else if (op == 4'h5) begin
        push(K_DRAIN, 64'(DRAIN_LEN), 64'd0);
      end else begin
        m_err = (op != 4'h0);
        push(K_DONE, 64'(m_err), regs_pack(m_ts, m_te, m_ls, m_le, m_ds, m_de));
        return;
      end
    end
  endtask

  task automatic observe(input int k, input logic [63:0] a, input logic [63:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d a=%0h b=%0h, expected no event", k, a, b);
      return;
    end
    e = exp_q.pop_front();
    cmp($sformatf("event_kind(exp %0d)", e.kind), 64'(k), 64'(e.kind));
    cmp($sformatf("event_a(kind %0d)", e.kind), a, e.a);
    cmp($sformatf("event_b(kind %0d)", e.kind), b, e.b);
  endtask

  initial begin : monitor
    bit pl, ps;
    logic [3:0] rv;
    int rl;
    pl = 0; ps = 0; rv = '0; rl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pl = 0; ps = 0; rv = '0; rl = 0;
        continue;
      end
      if (ld_req && !pl) observe(K_LD, 64'(ld_buf_id), 64'(ld_addr));
      if (st_req && !ps) observe(K_ST, 64'(st_addr), 64'd0);
      if (ctrl_state != rv) begin
        if (rv != 0) observe(rv == 1 ? K_STEADY : (rv == 2 ? K_DRAIN : 90 + int'(rv)), 64'(rl), 64'd0);
        rv = ctrl_state;
        rl = 1;
      end else begin
        rl++;
      end
      // busy must already be low in the done cycle, so it rides with err
      if (done) observe(K_DONE, {62'b0, busy, err},
                        regs_pack(top_rd_start, top_rd_end, left_rd_start, left_rd_end,
                                  down_rd_start, down_rd_end));
      pl = ld_req;
      ps = st_req;
    end
  end

  initial begin : ld_responder
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      ld_ack = 1'b0;
      if (ld_req && rst_n) begin
        if (c >= ack_dly) begin ld_ack = 1'b1; c = 0; end
        else c++;
      end else c = 0;
    end
  end

  initial begin : st_responder
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      st_ack = 1'b0;
      if (spur_st) begin
        st_ack = 1'b1;
        spur_st = 1'b0;
      end else if (st_req && rst_n && st_auto) begin
        if (c >= ack_dly) begin st_ack = 1'b1; c = 0; end
        else c++;
      end else c = 0;
    end
  end

  task automatic check_idle_outputs(input string nm);
    cmp({nm, "_ctl"}, {busy, done, err, inst_rd_en, ld_req, st_req, ctrl_state}, 64'd0);
    cmp({nm, "_addr"}, {inst_rd_addr, ld_buf_id, ld_addr, st_addr}, 64'd0);
    cmp({nm, "_rd"}, {top_rd_start, top_rd_end, left_rd_start, left_rd_end, down_rd_start, down_rd_end}, 64'd0);
  endtask

  task automatic run_prog(input logic [15:0] prog[$], input int dly, input bit poke);
    bit got_done, poked, patched;
    for (int i = 0; i < prog.size() && i < 1024; i++) imem[i] = prog[i];
    ack_dly = dly;
    model_run(prog);
    @(negedge clk);
    start = 1'b1;
    got_done = 0; poked = 0; patched = 0;
    for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && !poked && ctrl_state == 4'd1) begin start = 1'b1; poked = 1; end
      if (prog.size() > 1024 && !patched && ld_req) begin imem[0] = prog[1024]; patched = 1; end
      if (done) got_done = 1;
    end
    start = 1'b0;
    if (!got_done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done pulse, expected one within 6000 cycles");
    end
    repeat (3) @(negedge clk);
    cmp("err_sticky", 64'(err), 64'(m_err));
    cmp("busy_after_done", 64'(busy), 64'd0);
    cmp("events_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin : main
    logic [15:0] prog[$];
    bit seen;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected summary earlier");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] prog[$];
    bit seen;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    prog = '{mk(2,0,0), mk(2,1,16), mk(4,0,0), mk(5,0,0), mk(3,0,0), mk(0,0,0)};
    run_prog(prog, 3, 0);
    cmp("left_pair", {left_rd_start, left_rd_end}, {10'd0, 10'd14});
    cmp("top_pair", {top_rd_start, top_rd_end}, {10'd16, 10'd30});
    cmp("down_pair", {down_rd_start, down_rd_end}, {10'd0, 10'd7});
`ifdef GEMM_SEQ_PERF_CNT_EN
    cmp("perf_inst_cnt", 64'(perf_inst_cnt), 64'd6);
`endif

    prog = '{mk(2,2,0), mk(0,0,0)};
    run_prog(prog, 1, 0);
    cmp("illegal_err", 64'(err), 64'd1);

    prog = '{mk(2,0,1020), mk(0,0,0)};
    run_prog(prog, 0, 0);
    cmp("left_wrap", {left_rd_start, left_rd_end}, {10'd1020, 10'd10});

    prog = '{mk(4,1,5), mk(4,0,9), mk(0,0,0)};
    run_prog(prog, 2, 1);

    for (int r = 0; r < 15; r++) begin
      int n;
      prog.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        int sel, loc;
        sel = $urandom_range(0, 19);
        loc = $urandom_range(0, 1023);
        if (sel < 6)       prog.push_back(mk(2, $urandom_range(0, 1), loc));
        else if (sel < 9)  prog.push_back(mk(3, $urandom_range(0, 3), loc));
        else if (sel < 12) prog.push_back(mk(4, $urandom_range(0, 3), loc));
        else if (sel < 14) prog.push_back(mk(5, $urandom_range(0, 3), loc));
        else if (sel == 14) prog.push_back(mk(2, $urandom_range(2, 3), loc));
        else if (sel == 15) prog.push_back(mk($urandom_range(0, 1) ? 1 : $urandom_range(6, 15), $urandom_range(0, 3), loc));
        else               prog.push_back(mk(2 + $urandom_range(0, 1), $urandom_range(0, 1), loc));
      end
      prog.push_back(mk(0, $urandom_range(0, 3), $urandom_range(0, 1023)));
      run_prog(prog, $urandom_range(0, 4), 0);
    end

    // 1024 loads run pc through the top of memory; slot 0 becomes HALT once fetched.
    prog.delete();
    for (int i = 0; i < 1024; i++) prog.push_back(mk(2, i % 2, i));
    prog.push_back(mk(0, 0, 0));
    run_prog(prog, 0, 0);

    prog = '{mk(3,0,5), mk(0,0,0)};
    for (int i = 0; i < 2; i++) imem[i] = prog[i];
    st_auto = 1'b0;
    model_run(prog);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (st_req) seen = 1;
      else @(negedge clk);
    end
    cmp("st_req_before_reset", 64'(st_req), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("reset_in_store");
    exp_q.delete();
    m_ls = '0; m_le = '0; m_ts = '0; m_te = '0; m_ds = '0; m_de = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    spur_st = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("after_late_ack");
    st_auto = 1'b1;

    prog = '{mk(3,0,1020), mk(2,1,1015), mk(0,0,0)};
    run_prog(prog, 2, 0);
    cmp("down_wrap", {down_rd_start, down_rd_end}, {10'd1020, 10'd3});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gemm_inst_sequencer.md
GEMM_INST_SEQUENCER -- requirements
Module: gemm_inst_sequencer

Interface
REQ-001 SHALL have parameters: INST_WIDTH=16 (instruction bits); LOG2_INST_MEMORY_SIZE=10 (PC width); NUM_ROW=8 and NUM_COL=8 (array dims); LOG2_SRAM_BANK_DEPTH=10 (SRAM address width); CTRL_WIDTH=4 (controller state width).
REQ-002 SHALL use one clock and asynchronous active-low reset: clk in 1 (rising edge); rst_n in 1 (async assert, active low).
REQ-003 SHALL have program ports: start in 1 (pulse, begins program at PC=0); busy out 1 (program running); done out 1 (one-cycle pulse at program end); err out 1 (sticky illegal-instruction flag).
REQ-004 SHALL have instruction memory ports: inst_rd_en out 1; inst_rd_addr out LOG2_INST_MEMORY_SIZE; inst_rd_data in INST_WIDTH (valid 1 cycle after inst_rd_en).
REQ-005 SHALL have load engine ports: ld_req out 1; ld_buf_id out 2; ld_addr out LOG2_SRAM_BANK_DEPTH; ld_ack in 1 (one-cycle pulse when load completes).
REQ-006 SHALL have store engine ports: st_req out 1; st_addr out LOG2_SRAM_BANK_DEPTH; st_ack in 1 (one-cycle pulse).
REQ-007 SHALL drive controller outputs: ctrl_state out CTRL_WIDTH; top_rd_start/top_rd_end, left_rd_start/left_rd_end, down_rd_start/down_rd_end out LOG2_SRAM_BANK_DEPTH each.

Function
REQ-008 SHALL split each instruction into opcode[15:12], buf_id[11:10] and mem_loc[9:0].
REQ-009 SHALL implement FSM states IDLE, FETCH, DECODE, LOAD, STORE, GEMM, DRAIN.
REQ-010 SHALL, in IDLE, on start=1 clear PC to 0, set busy=1 and enter FETCH; start SHALL be ignored while busy=1.
REQ-011 SHALL, in FETCH, assert inst_rd_en=1 with inst_rd_addr=PC for one cycle and enter DECODE; DECODE SHALL register inst_rd_data.
REQ-012 SHALL dispatch from DECODE by opcode: 0010 LD, 0011 ST, 0100 GEMM, 0101 DRAINSYS, 0000 HALT.
REQ-013 SHALL treat HALT as end of program: return to IDLE, busy=0, done=1 for exactly one cycle.
REQ-014 SHALL treat any other opcode, or LD with buf_id 10/11, as illegal: set err=1, then end the program as for HALT.
REQ-015 SHALL, in LOAD, hold ld_req=1 with ld_buf_id=buf_id and ld_addr=mem_loc until ld_ack=1 is sampled.
REQ-016 SHALL, on ld_ack, set start=mem_loc and end=(mem_loc+NUM_ROW+NUM_COL-2) mod 2^LOG2_SRAM_BANK_DEPTH on the left pair (buf_id 00) or the top pair (buf_id 01), drop ld_req in the same edge, PC+1, and enter FETCH.
REQ-017 SHALL, in STORE, hold st_req=1 with st_addr=mem_loc until st_ack; on ack set down_rd_start=mem_loc, down_rd_end=(mem_loc+NUM_ROW-1) truncated, PC+1, then FETCH.
REQ-018 SHALL ignore ld_ack and st_ack whenever the matching req is low.
REQ-019 SHALL, in GEMM, drive ctrl_state=CTRL_STEADY for exactly NUM_ROW+NUM_COL-1 cycles (15 at 8x8), then CTRL_IDLE, PC+1, then FETCH.
REQ-020 SHALL, in DRAIN, drive ctrl_state=CTRL_DRAIN for exactly NUM_ROW cycles, then behave as in REQ-019.
REQ-021 SHALL drive ctrl_state=CTRL_IDLE in every other state.
REQ-022 SHALL wrap PC from 2^LOG2_INST_MEMORY_SIZE-1 to 0 without flagging an error.
REQ-023 SHALL clear err only on reset or on an accepted start.

Reset
REQ-024 SHALL, on rst_n=0, immediately enter IDLE and force PC=0 and all outputs to 0 (ctrl_state=CTRL_IDLE=0), including while a request is pending; a later ack SHALL be ignored.

Configuration
REQ-025 SHALL, with GEMM_SEQ_PERF_CNT_EN defined, add 32-bit outputs perf_inst_cnt (instructions decoded) and perf_busy_cyc (cycles with busy=1), cleared on start and reset and saturating at all-ones; without the macro these ports and their logic SHALL be absent.

Structure
REQ-026 SHALL take the opcode constants, the field widths and CTRL_IDLE=0/CTRL_STEADY=1/CTRL_DRAIN=2 from shared package gemm_isa_pkg.
REQ-027 SHALL place instruction field extraction and legality checking in one combinational sub-module, gemm_inst_decode.

Verification
REQ-028 Program {LD buf0 @0, LD buf1 @16, GEMM, DRAINSYS, ST @0, HALT}, acks after 3 cycles -> left 0/14, top 16/30, STEADY 15 cycles, DRAIN 8 cycles, down 0/7, done pulse, err=0.
REQ-029 LD buf_id 10 at PC=0 -> err=1, no ld_req, done pulse, busy=0.
REQ-030 LD @1020 -> left_rd_start=1020, left_rd_end=10 (wrap).
REQ-031 Reset asserted while st_req=1, then st_ack pulsed -> all outputs 0, FSM stays in IDLE.
REQ-032 start pulsed during GEMM -> ignored, PC continues, exactly one done pulse.
REQ-033 With GEMM_SEQ_PERF_CNT_EN, REQ-028 program -> perf_inst_cnt=6.
